// File: rtl/enc42_pkg.sv
// Shared types and constants for the enc42_rr registered 4-to-2 encoder.
//   idx2_t    : 2-bit line index / code
//   MODE_PRIO : multi-hot resolved by fixed priority (IN3 highest)
//   MODE_RR   : multi-hot resolved round-robin
//   PTR_RST   : round-robin pointer reset value
package enc42_pkg;

    typedef logic [1:0] idx2_t;

    localparam int unsigned MODE_PRIO = 0;
    localparam int unsigned MODE_RR   = 1;

    localparam idx2_t PTR_RST = 2'd3;

endpackage

// File: rtl/enc42_rr_if.sv
// Request/code bundle for enc42_rr.
//   en        : sample enable
//   clr       : synchronous clear of err
//   in0..in3  : request lines (one-hot select bus)
//   out1/out2 : registered code MSB/LSB
//   vld       : last sample held at least one request
//   err       : a multi-hot sample was seen
// master drives requests and reads the code; slave is the encoder.
interface enc42_rr_if;
    logic en;
    logic clr;
    logic in0;
    logic in1;
    logic in2;
    logic in3;
    logic out1;
    logic out2;
    logic vld;
    logic err;

    modport master (
        output en, clr, in0, in1, in2, in3,
        input  out1, out2, vld, err
    );

    modport slave (
        input  en, clr, in0, in1, in2, in3,
        output out1, out2, vld, err
    );
endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-request picker.
//   req     : request vector, bit k = line k
//   ptr     : last granted index (round-robin only)
//   mode    : 0 = highest index wins, 1 = first high line searching up from ptr+1
//   gnt_idx : granted index (0 when no request)
//   any     : at least one request
//   multi   : two or more requests
module rr_pick4
    import enc42_pkg::*;
(
    input  logic [3:0] req,
    input  idx2_t      ptr,
    input  logic       mode,
    output idx2_t      gnt_idx,
    output logic       any,
    output logic       multi
);

    always_comb begin
        idx2_t idx;
        logic  found;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        if (mode) begin
            // Offsets 1..4 from ptr; 2-bit add wraps 3 -> 0.
            for (int i = 0; i < 4; i++) begin
                idx = ptr + idx2_t'(i + 1);
                if (!found && req[idx]) begin
                    gnt_idx = idx;
                    found   = 1'b1;
                end
            end
        end else begin
            // Later iterations overwrite, so the highest index wins.
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    gnt_idx = idx2_t'(i);
                end
            end
        end
    end

    assign any   = |req;
    assign multi = ($countones(req) > 1);

endmodule

// File: rtl/enc42_rr.sv
// Registered 4-to-2 encoder with multi-hot detection.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : enc42_rr_if slave (en, clr, in0..in3 in; out1, out2, vld, err out)
// Parameters:
//   MODE   : MODE_PRIO (fixed priority) or MODE_RR (round-robin)
//   STICKY : 1 = err holds until clr, 0 = err tracks the latest sample
// All outputs come straight from flops; latency is one cycle.
module enc42_rr
    import enc42_pkg::*;
#(
    parameter int unsigned MODE   = MODE_PRIO,
    parameter int unsigned STICKY = 1
) (
    input logic       clk,
    input logic       rst,
    enc42_rr_if.slave bus
);

    logic [3:0] req;
    idx2_t      gnt_idx;
    logic       any;
    logic       multi;

    idx2_t code_q, code_d;
    idx2_t ptr_q, ptr_d;
    logic  vld_q, vld_d;
    logic  err_q, err_d;

    assign req = {bus.in3, bus.in2, bus.in1, bus.in0};

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .mode    (MODE == MODE_RR),
        .gnt_idx (gnt_idx),
        .any     (any),
        .multi   (multi)
    );

    always_comb begin
        code_d = code_q;
        ptr_d  = ptr_q;
        vld_d  = vld_q;
        err_d  = err_q;
        if (bus.en) begin
            vld_d = any;
            // An empty sample keeps the old code and pointer.
            if (any) begin
                code_d = gnt_idx;
                if (MODE == MODE_RR) begin
                    ptr_d = gnt_idx;
                end
            end
            if (STICKY != 0) begin
                if (multi) begin
                    err_d = 1'b1;
                end
            end else begin
                err_d = multi;
            end
        end
        // A multi-hot sample on the same edge beats the clear.
        if (bus.clr && !(bus.en && multi)) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= '0;
            ptr_q  <= PTR_RST;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            code_q <= code_d;
            ptr_q  <= ptr_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
        end
    end

    assign bus.out1 = code_q[1];
    assign bus.out2 = code_q[0];
    assign bus.vld  = vld_q;
    assign bus.err  = err_q;

endmodule
